// File: rtl/reg_dump.sv
// reg_dump: debug readout engine for the 32x32 register file.
// On a start request it reads every register through a spare read port and
// streams a 130-byte frame over a valid/ready byte channel:
//   0xA5, then 4 bytes per register (MSB first), then an 8-bit checksum
//   of the 128 data bytes (header excluded).
module reg_dump #(
  parameter int REG_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_OF_REGS    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [REG_ADDR_WIDTH-1:0] r_addr,
  input  logic [REG_WIDTH-1:0]      r_data,
  output logic [7:0]                byte_out,
  output logic                      byte_valid,
  input  logic                      byte_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
    S_SEND,
    S_CSUM,
    S_DONE
  } state_t;

  localparam logic [7:0]                HDR_BYTE = 8'hA5;
  localparam logic [REG_ADDR_WIDTH-1:0] LAST_IDX = REG_ADDR_WIDTH'(NUM_OF_REGS - 1);

  state_t                    state;
  state_t                    state_nxt;
  logic [REG_ADDR_WIDTH-1:0] idx;
  logic [7:0]                sum;
  logic [REG_WIDTH-1:0]      word;
  logic [1:0]                byte_cnt;
  logic                      xfer;
  logic                      last_byte;

  // A transfer needs both sides; byte_valid itself comes only from state.
  assign xfer      = byte_valid & byte_ready;
  assign last_byte = (byte_cnt == 2'd3);

  // State register with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; every state holds until its handshake completes.
  // NOTE: the default assignment first guarantees no latch is inferred for
  // paths that do not assign state_nxt.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (start) state_nxt = S_HDR;
      S_HDR:  if (xfer)  state_nxt = S_LOAD;
      S_LOAD:            state_nxt = S_SEND;
      S_SEND: if (xfer && last_byte) state_nxt = (idx == LAST_IDX) ? S_CSUM : S_LOAD;
      S_CSUM: if (xfer)  state_nxt = S_DONE;
      S_DONE:            state_nxt = S_IDLE;
      default:           state_nxt = S_IDLE;
    endcase
  end

  // Datapath: register index, running checksum, in-flight word, byte counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx      <= '0;
      sum      <= '0;
      word     <= '0;
      byte_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            idx <= '0;
            sum <= '0;
          end
        end
        S_LOAD: begin
          // Snapshot the register now; later file writes do not disturb it.
          word     <= r_data;
          byte_cnt <= '0;
        end
        S_SEND: begin
          if (xfer) begin
            sum      <= sum + word[REG_WIDTH-1 -: 8];
            word     <= word << 8;
            byte_cnt <= byte_cnt + 2'd1;
            if (last_byte && idx != LAST_IDX) idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from state; stable while waiting for byte_ready.
  always_comb begin
    busy       = 1'b1;
    done       = 1'b0;
    byte_valid = 1'b0;
    byte_out   = 8'h00;
    r_addr     = idx;
    unique case (state)
      S_IDLE: begin
        busy   = 1'b0;
        r_addr = '0;
      end
      S_HDR: begin
        byte_valid = 1'b1;
        byte_out   = HDR_BYTE;
      end
      S_LOAD: ;
      S_SEND: begin
        byte_valid = 1'b1;
        byte_out   = word[REG_WIDTH-1 -: 8];
      end
      S_CSUM: begin
        byte_valid = 1'b1;
        byte_out   = sum;
      end
      S_DONE: done = 1'b1;
      default: begin
        busy   = 1'b0;
        r_addr = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump: directed bench for reg_dump. A behavioural register file
// feeds r_data; inputs are driven and outputs sampled on the falling edge.
// Edge index k counts rising edges after the start edge E0.
module tb_reg_dump;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  r_addr;
  logic [31:0] r_data;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;

  logic [31:0] rf [32];
  logic [7:0]  got_q [$];
  logic [7:0]  exp_q [$];

  int checks   = 0;
  int failures = 0;
  int done_cnt;
  int done_edge;
  int stalls;
  int stab_bad;
  int end_k;

  reg_dump #(
    .REG_WIDTH      (32),
    .REG_ADDR_WIDTH (5),
    .NUM_OF_REGS    (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .r_addr     (r_addr),
    .r_data     (r_data),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready)
  );

  always #5 clk = ~clk;

  // Combinational read port of the register file model.
  assign r_data = rf[r_addr];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic fill_index();
    for (int n = 0; n < 32; n++) rf[n] = n;
  endtask

  // Expected frame from the register file contents at call time.
  task automatic build_exp();
    logic [7:0] s;
    logic [31:0] w;
    s = 8'h00;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int n = 0; n < 32; n++) begin
      w = rf[n];
      for (int b = 3; b >= 0; b--) begin
        exp_q.push_back(w[8*b +: 8]);
        s = s + w[8*b +: 8];
      end
    end
    exp_q.push_back(s);
  endtask

  task automatic compare_frame(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 130; i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    check({tag, "_len"}, got_q.size(), 130);
    check({tag, "_bytes_bad"}, bad, 0);
  endtask

  // Run one dump. mode 1 randomises byte_ready; repulse re-asserts start at
  // k=10 and k=100; write5 changes r[5] right after its LOAD; abort_at>0
  // pulses rst_n once that many bytes have transferred.
  task automatic dump(input int mode, input bit repulse, input bit write5, input int abort_at);
    bit         prev_stall;
    logic [7:0] prev_byte;
    bit         fin;
    got_q.delete();
    done_cnt   = 0;
    done_edge  = -1;
    stalls     = 0;
    stab_bad   = 0;
    end_k      = -1;
    prev_stall = 1'b0;
    prev_byte  = 8'h00;
    fin        = 1'b0;
    @(negedge clk);
    start      = 1'b1;
    byte_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_valid", byte_valid, 1);
    check("start_hdr", byte_out, 8'hA5);
    for (int k = 1; k < 2000; k++) begin
      if (abort_at > 0 && got_q.size() == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_valid", byte_valid, 0);
        check("abort_busy", busy, 0);
        repeat (5) begin
          if (done) done_cnt++;
          @(negedge clk);
        end
        fin = 1'b1;
        break;
      end
      if (write5 && k == 28) rf[5] = 32'h12345678;
      start      = repulse && (k == 10 || k == 100);
      byte_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done) begin
        done_cnt++;
        done_edge = k - 1;
      end
      if (prev_stall && (!byte_valid || byte_out !== prev_byte)) stab_bad++;
      prev_stall = 1'b0;
      if (byte_valid) begin
        if (byte_ready) got_q.push_back(byte_out);
        else begin
          stalls++;
          prev_stall = 1'b1;
          prev_byte  = byte_out;
        end
      end
      if (!busy) begin
        end_k = k;
        fin   = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!fin) check("timeout", 0, 1);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_ready = 1'b0;
    fill_index();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", byte_valid, 0);
    check("rst_byte", byte_out, 8'h00);
    check("rst_addr", r_addr, 0);

    // r[n]=n, ready high: checksum 0+1+..+31 = 496 mod 256 = 0xF0.
    build_exp();
    dump(0, 1'b0, 1'b0, 0);
    compare_frame("idx");
    check("idx_hdr", got_q[0], 8'hA5);
    check("idx_csum", got_q[129], 8'hF0);
    check("idx_done_cnt", done_cnt, 1);
    check("idx_done_edge", done_edge, 162);
    check("idx_busy_fall", end_k, 164);
    check("idx_idle_addr", r_addr, 0);

    // r[n]=0xFFFFFFFF for n>=1: checksum 124*0xFF mod 256 = 0x84.
    for (int n = 1; n < 32; n++) rf[n] = 32'hFFFF_FFFF;
    build_exp();
    dump(0, 1'b0, 1'b0, 0);
    compare_frame("ones");
    check("ones_csum", got_q[129], 8'h84);
    check("ones_b4", got_q[4], 8'h00);
    check("ones_b5", got_q[5], 8'hFF);

    // Random back-pressure: same frame, stable while stalled, latency grows.
    fill_index();
    build_exp();
    dump(1, 1'b0, 1'b0, 0);
    compare_frame("rnd");
    check("rnd_stable_bad", stab_bad, 0);
    check("rnd_done_cnt", done_cnt, 1);
    check("rnd_latency", done_edge, 162 + stalls);

    // Start re-pulsed mid-dump: ignored.
    dump(0, 1'b1, 1'b0, 0);
    compare_frame("rep");
    check("rep_done_cnt", done_cnt, 1);
    check("rep_done_edge", done_edge, 162);

    // Reset after 40 bytes: abandoned, no done; next dump is a full frame.
    dump(0, 1'b0, 1'b0, 40);
    check("abort_done_cnt", done_cnt, 0);
    dump(0, 1'b0, 1'b0, 0);
    compare_frame("post");
    check("post_hdr", got_q[0], 8'hA5);
    check("post_done_cnt", done_cnt, 1);

    // r[5] written just after its LOAD: first frame carries old value 5.
    build_exp();
    dump(0, 1'b0, 1'b1, 0);
    compare_frame("wr_old");
    check("wr_old_r5", got_q[24], 8'h05);
    build_exp();
    dump(0, 1'b0, 1'b0, 0);
    compare_frame("wr_new");
    check("wr_new_b21", got_q[21], 8'h12);
    check("wr_new_b22", got_q[22], 8'h34);
    check("wr_new_b23", got_q[23], 8'h56);
    check("wr_new_b24", got_q[24], 8'h78);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
